// File: rtl/fitness_eval_ctrl_if.sv
// Bus between the fitness sequencer and its environment: GA control,
// population/fitness memories and the fitness evaluator.
// Signal suffixes (_i/_o) are from the sequencer's point of view.
interface fitness_eval_ctrl_if #(
  parameter int ADDR_WIDTH               = 6,
  parameter int INDIVIDUAL_LENGTH        = 22,
  parameter int SELF_ENERGY_VEC_LENGTH   = 12,
  parameter int INTERATION_MATRIX_LENGTH = 36,
  parameter int SELF_FIT_LENGTH          = 10
);
  logic                                start_i;
  logic                                bank_sel_i;
  logic [SELF_ENERGY_VEC_LENGTH-1:0]   self_energy_vec_i;
  logic [INTERATION_MATRIX_LENGTH-1:0] interact_matrix_i;
  logic                                pop_rd_en_o;
  logic [ADDR_WIDTH-1:0]               pop_rd_addr_o;
  logic [INDIVIDUAL_LENGTH-1:0]        pop_rd_data_i;
  logic                                eval_set_data_o;
  logic [SELF_ENERGY_VEC_LENGTH-1:0]   eval_self_energy_o;
  logic [INTERATION_MATRIX_LENGTH-1:0] eval_interact_o;
  logic                                eval_in_valid_o;
  logic [INDIVIDUAL_LENGTH-1:0]        eval_ind_vec_o;
  logic                                eval_ind_idx_o;
  logic                                eval_out_valid_i;
  logic [SELF_FIT_LENGTH-1:0]          eval_total_energy_i;
  logic                                eval_ind_wb_idx_i;
  logic                                fit_wr_en_o;
  logic                                fit_wr_bank_o;
  logic [ADDR_WIDTH-1:0]               fit_wr_addr_o;
  logic [SELF_FIT_LENGTH-1:0]          fit_wr_data_o;
  logic [SELF_FIT_LENGTH-1:0]          best_energy_o;
  logic [ADDR_WIDTH-1:0]               best_idx_o;
  logic                                busy_o;
  logic                                done_o;
  logic                                err_o;

  // sequencer side
  modport master (
    input  start_i, bank_sel_i, self_energy_vec_i, interact_matrix_i,
           pop_rd_data_i, eval_out_valid_i, eval_total_energy_i, eval_ind_wb_idx_i,
    output pop_rd_en_o, pop_rd_addr_o, eval_set_data_o, eval_self_energy_o,
           eval_interact_o, eval_in_valid_o, eval_ind_vec_o, eval_ind_idx_o,
           fit_wr_en_o, fit_wr_bank_o, fit_wr_addr_o, fit_wr_data_o,
           best_energy_o, best_idx_o, busy_o, done_o, err_o
  );

  // environment side
  modport slave (
    output start_i, bank_sel_i, self_energy_vec_i, interact_matrix_i,
           pop_rd_data_i, eval_out_valid_i, eval_total_energy_i, eval_ind_wb_idx_i,
    input  pop_rd_en_o, pop_rd_addr_o, eval_set_data_o, eval_self_energy_o,
           eval_interact_o, eval_in_valid_o, eval_ind_vec_o, eval_ind_idx_o,
           fit_wr_en_o, fit_wr_bank_o, fit_wr_addr_o, fit_wr_data_o,
           best_energy_o, best_idx_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/fitness_eval_ctrl.sv
// Fitness evaluation sequencer: loads the energy tables into the evaluator,
// streams every individual of the selected bank through it, writes each
// returned energy to fitness memory and tracks the minimum-energy individual.
module fitness_eval_ctrl #(
  parameter int POP_SIZE                 = 50,
  parameter int ADDR_WIDTH               = 6,
  parameter int INDIVIDUAL_LENGTH        = 22,
  parameter int SELF_ENERGY_VEC_LENGTH   = 12,
  parameter int INTERATION_MATRIX_LENGTH = 36,
  parameter int SELF_FIT_LENGTH          = 10,
  parameter int TIMEOUT                  = 15
) (
  input logic clk_i,
  input logic rst_i,
  fitness_eval_ctrl_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(POP_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] POP_CNT   = ADDR_WIDTH'(POP_SIZE);
  localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH-1:0]               res_cnt_q, res_cnt_d;
  logic [WD_W-1:0]                     wd_q, wd_d;
  logic [SELF_ENERGY_VEC_LENGTH-1:0]   se_q, se_d;
  logic [INTERATION_MATRIX_LENGTH-1:0] im_q, im_d;
  logic                                bank_q, bank_d;
  logic                                in_vld_q, in_vld_d;
  logic                                wr_en_q, wr_en_d;
  logic                                wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0]               wr_addr_q, wr_addr_d;
  logic [SELF_FIT_LENGTH-1:0]          wr_data_q, wr_data_d;
  logic [SELF_FIT_LENGTH-1:0]          best_e_q, best_e_d;
  logic [ADDR_WIDTH-1:0]               best_idx_q, best_idx_d;
  logic                                err_q, err_d;
  logic                                res_ok;

  // results only count while a pass is streaming or draining
  assign res_ok = bus.eval_out_valid_i && (state_q == S_ISSUE || state_q == S_DRAIN);

  // next-state, counters, capture, result write-back and best tracking
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    wd_d        = wd_q;
    se_d        = se_q;
    im_d        = im_q;
    bank_d      = bank_q;
    in_vld_d    = (state_q == S_ISSUE);
    wr_en_d     = 1'b0;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    best_e_d    = best_e_q;
    best_idx_d  = best_idx_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: if (bus.start_i) begin
        state_d     = S_CFG;
        se_d        = bus.self_energy_vec_i;
        im_d        = bus.interact_matrix_i;
        bank_d      = bus.bank_sel_i;
        issue_cnt_d = '0;
        res_cnt_d   = '0;
        wd_d        = '0;
        best_e_d    = '1;
        best_idx_d  = '0;
        err_d       = 1'b0;
      end
      S_CFG:   state_d = S_ISSUE;
      S_ISSUE: begin
        if (issue_cnt_q == LAST_ADDR) state_d = S_DRAIN;
        else issue_cnt_d = issue_cnt_q + ADDR_WIDTH'(1);
      end
      S_DRAIN: begin
        if (res_cnt_q == POP_CNT) begin
          state_d = S_DONE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // strict less-than keeps the earlier index on ties
    if (res_ok) begin
      if (res_cnt_q < POP_CNT) begin
        wr_en_d   = 1'b1;
        wr_addr_d = res_cnt_q;
        wr_data_d = bus.eval_total_energy_i;
        wr_bank_d = bus.eval_ind_wb_idx_i;
        res_cnt_d = res_cnt_q + ADDR_WIDTH'(1);
        if (bus.eval_total_energy_i < best_e_q) begin
          best_e_d   = bus.eval_total_energy_i;
          best_idx_d = res_cnt_q;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // state and datapath registers, synchronous reset aborts any pass
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      wd_q        <= '0;
      se_q        <= '0;
      im_q        <= '0;
      bank_q      <= 1'b0;
      in_vld_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      best_e_q    <= '1;
      best_idx_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      wd_q        <= wd_d;
      se_q        <= se_d;
      im_q        <= im_d;
      bank_q      <= bank_d;
      in_vld_q    <= in_vld_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      best_e_q    <= best_e_d;
      best_idx_q  <= best_idx_d;
      err_q       <= err_d;
    end
  end

  assign bus.pop_rd_en_o        = (state_q == S_ISSUE);
  assign bus.pop_rd_addr_o      = issue_cnt_q;
  assign bus.eval_set_data_o    = (state_q == S_CFG);
  assign bus.eval_self_energy_o = se_q;
  assign bus.eval_interact_o    = im_q;
  assign bus.eval_in_valid_o    = in_vld_q;
  // memory data is passed straight through, zeroed when no read is returning
  assign bus.eval_ind_vec_o     = in_vld_q ? bus.pop_rd_data_i : {INDIVIDUAL_LENGTH{1'b0}};
  assign bus.eval_ind_idx_o     = bank_q;
  assign bus.fit_wr_en_o        = wr_en_q;
  assign bus.fit_wr_bank_o      = wr_bank_q;
  assign bus.fit_wr_addr_o      = wr_addr_q;
  assign bus.fit_wr_data_o      = wr_data_q;
  assign bus.best_energy_o      = best_e_q;
  assign bus.best_idx_o         = best_idx_q;
  assign bus.busy_o             = (state_q != S_IDLE);
  assign bus.done_o             = (state_q == S_DONE);
  assign bus.err_o              = err_q;
endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Bench for fitness_eval_ctrl: a behavioural population memory and a
// fixed-latency evaluator drive the sequencer; each pass is scored against
// the expected write list, timeline and minimum computed from the tables.
module tb_fitness_eval_ctrl;
  localparam int POP = 50, AW = 6, IL = 22, SEL = 12, IML = 36, SFL = 10, TO = 15;

  logic clk = 1'b0;
  logic rst;
  int   cyc, total = 0, bad = 0;

  fitness_eval_ctrl_if #(.ADDR_WIDTH(AW), .INDIVIDUAL_LENGTH(IL), .SELF_ENERGY_VEC_LENGTH(SEL),
    .INTERATION_MATRIX_LENGTH(IML), .SELF_FIT_LENGTH(SFL)) bus ();

  fitness_eval_ctrl #(.POP_SIZE(POP), .ADDR_WIDTH(AW), .INDIVIDUAL_LENGTH(IL),
    .SELF_ENERGY_VEC_LENGTH(SEL), .INTERATION_MATRIX_LENGTH(IML), .SELF_FIT_LENGTH(SFL),
    .TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int c; int a; int d; int b; } wr_t;

  logic [IL-1:0]  pop_mem [POP];
  logic [SFL-1:0] etab [POP];
  bit             rd_pend;
  logic [AW-1:0]  rd_addr_prev;
  bit             pv [4];
  int             pidx [4];
  bit             pb [4];
  int             feed_n, supp_n, inject_cyc;
  wr_t            wq [$];
  int             done_cyc, done_n, set_n, set_first, rd_n, rd_first, iv_n, iv_first, tbl_bad;
  logic [SEL-1:0] exp_se;
  logic [IML-1:0] exp_im;
  bit             exp_bank;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one clock: memory read return, evaluator pipeline, output monitors
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    bus.pop_rd_data_i = (rd_pend && rd_addr_prev < POP) ? pop_mem[rd_addr_prev] : IL'($urandom);
    rd_pend      = bus.pop_rd_en_o;
    rd_addr_prev = bus.pop_rd_addr_o;
    bus.eval_out_valid_i    = pv[3] && (pidx[3] < POP - supp_n);
    bus.eval_total_energy_i = pv[3] ? etab[pidx[3]] : SFL'($urandom);
    bus.eval_ind_wb_idx_i   = pb[3];
    if (cyc == inject_cyc) begin
      bus.eval_out_valid_i    = 1'b1;
      bus.eval_total_energy_i = '0;
      bus.eval_ind_wb_idx_i   = 1'b0;
    end
    #1;
    for (int k = 3; k > 0; k--) begin
      pv[k] = pv[k-1]; pidx[k] = pidx[k-1]; pb[k] = pb[k-1];
    end
    pv[0]   = bus.eval_in_valid_o;
    pidx[0] = (feed_n < POP) ? feed_n : 0;
    pb[0]   = bus.eval_ind_idx_o;
    if (bus.eval_in_valid_o) begin
      if (feed_n < POP) chk("ind_vec", 64'(bus.eval_ind_vec_o), 64'(pop_mem[feed_n]));
      feed_n++;
      iv_n++;
      if (iv_first < 0) iv_first = cyc;
    end
    if (bus.pop_rd_en_o) begin rd_n++; if (rd_first < 0) rd_first = cyc; end
    if (bus.eval_set_data_o) begin set_n++; if (set_first < 0) set_first = cyc; end
    if (bus.done_o) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
    if (bus.fit_wr_en_o)
      wq.push_back('{c: cyc, a: int'(bus.fit_wr_addr_o), d: int'(bus.fit_wr_data_o), b: int'(bus.fit_wr_bank_o)});
    if (bus.busy_o && (bus.eval_self_energy_o !== exp_se || bus.eval_interact_o !== exp_im ||
                       bus.eval_ind_idx_o !== exp_bank)) tbl_bad++;
  endtask

  // one evaluation pass; start_i is high in cycle 0
  task automatic run_pass(input bit bank, input int supp, input int busy_at,
                          input int inject_at, input int rst_at);
    int n_exp, done_exp, min_e, best_i;
    bit err_exp;
    supp_n = supp; inject_cyc = inject_at; feed_n = 0; wq.delete();
    done_cyc = -1; done_n = 0; set_n = 0; set_first = -1;
    rd_n = 0; rd_first = -1; iv_n = 0; iv_first = -1; tbl_bad = 0;
    for (int i = 0; i < POP; i++) pop_mem[i] = IL'($urandom);
    cyc = -1;
    tick();
    exp_se = SEL'($urandom); exp_im = IML'({$urandom, $urandom}); exp_bank = bank;
    bus.start_i = 1'b1; bus.bank_sel_i = bank;
    bus.self_energy_vec_i = exp_se; bus.interact_matrix_i = exp_im;
    while (cyc < 95) begin
      tick();
      if (cyc == 1) begin
        bus.start_i = 1'b0; bus.bank_sel_i = ~bank;
        bus.self_energy_vec_i = ~exp_se; bus.interact_matrix_i = ~exp_im;
      end
      if (cyc == busy_at) bus.start_i = 1'b1;
      if (busy_at >= 0 && cyc == busy_at + 1) bus.start_i = 1'b0;
      if (cyc == rst_at) rst = 1'b1;
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_strobes", 64'({bus.pop_rd_en_o, bus.eval_set_data_o, bus.eval_in_valid_o,
                                bus.fit_wr_en_o, bus.done_o, bus.err_o}), 64'(0));
        chk("rst_best", 64'({bus.best_energy_o, bus.best_idx_o}), 64'({{SFL{1'b1}}, AW'(0)}));
        rst = 1'b0;
      end
    end

    n_exp = (rst_at >= 0) ? rst_at - 7 : POP - supp;
    chk("wr_count", 64'(wq.size()), 64'(n_exp));
    for (int j = 0; j < wq.size() && j < n_exp; j++)
      chk("wr", {16'(wq[j].c), 16'(wq[j].a), 16'(wq[j].d), 16'(wq[j].b)},
                {16'(8 + j), 16'(j), 16'(etab[j]), 16'(bank)});
    chk("set_data", {32'(set_n), 32'(set_first)}, {32'(1), 32'(1)});
    chk("tables_held", 64'(tbl_bad), 64'(0));
    if (rst_at >= 0) begin
      chk("rst_no_done", 64'(done_n), 64'(0));
    end else begin
      done_exp = (supp > 0) ? POP + 2 + TO : POP + 8;
      err_exp  = (supp > 0) || (inject_at > POP + 6 && inject_at < done_exp);
      min_e = (1 << SFL) - 1;
      for (int i = 0; i < POP - supp; i++) if (int'(etab[i]) < min_e) min_e = int'(etab[i]);
      best_i = 0;
      for (int i = POP - supp - 1; i >= 0; i--) if (int'(etab[i]) == min_e) best_i = i;
      chk("done", {32'(done_n), 32'(done_cyc)}, {32'(1), 32'(done_exp)});
      chk("rd_en", {32'(rd_n), 32'(rd_first)}, {32'(POP), 32'(2)});
      chk("in_valid", {32'(iv_n), 32'(iv_first)}, {32'(POP), 32'(3)});
      chk("best_energy", 64'(bus.best_energy_o), 64'(min_e));
      chk("best_idx", 64'(bus.best_idx_o), 64'(best_i));
      chk("err", 64'(bus.err_o), 64'(err_exp));
      chk("idle_after", 64'(bus.busy_o), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.bank_sel_i = 1'b0;
    bus.self_energy_vec_i = '0; bus.interact_matrix_i = '0; bus.pop_rd_data_i = '0;
    bus.eval_out_valid_i = 1'b0; bus.eval_total_energy_i = '0; bus.eval_ind_wb_idx_i = 1'b0;
    cyc = -100; inject_cyc = -1000; supp_n = 0; feed_n = 0;
    exp_se = '0; exp_im = '0; exp_bank = 1'b0;
    for (int k = 0; k < 4; k++) begin pv[k] = 0; pidx[k] = 0; pb[k] = 0; end
    repeat (3) tick();
    chk("reset_strobes", 64'({bus.pop_rd_en_o, bus.eval_set_data_o, bus.eval_in_valid_o,
                              bus.fit_wr_en_o, bus.done_o, bus.err_o, bus.busy_o}), 64'(0));
    chk("reset_best", 64'({bus.best_energy_o, bus.best_idx_o}), 64'({{SFL{1'b1}}, AW'(0)}));
    chk("reset_wr", 64'({bus.fit_wr_addr_o, bus.fit_wr_data_o, bus.fit_wr_bank_o}), 64'(0));
    rst = 1'b0;
    repeat (2) tick();

    // nominal: energy = 10 + index
    for (int i = 0; i < POP; i++) etab[i] = SFL'(10 + i);
    run_pass(1'b0, 0, -1, -1, -1);

    // minimum shared by individuals 17 and 33
    for (int i = 0; i < POP; i++) etab[i] = SFL'($urandom_range(1023, 4));
    etab[17] = SFL'(3); etab[33] = SFL'(3);
    run_pass(1'b0, 0, -1, -1, -1);

    // bank 1, start while busy, stray result in IDLE after the pass
    for (int i = 0; i < POP; i++) etab[i] = SFL'($urandom);
    run_pass(1'b1, 0, 20, 62, -1);

    // dense ties; one extra result after the pass is complete
    for (int i = 0; i < POP; i++) etab[i] = SFL'($urandom_range(7, 0));
    run_pass(1'b0, 0, -1, POP + 7, -1);

    // watchdog: last two results never come back
    for (int i = 0; i < POP; i++) etab[i] = SFL'(10 + i);
    run_pass(1'b1, 2, -1, -1, -1);

    // reset in the middle of a pass, then a clean pass
    for (int i = 0; i < POP; i++) etab[i] = SFL'($urandom);
    run_pass(1'b0, 0, -1, -1, 30);
    run_pass(1'b1, 0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
